log_space_ctrl: RTL and testbench
=================================

LOG_SPACE_CTRL -- requirements
Module: log_space_ctrl

Interface
REQ-001 SHALL have parameter LOG_DEPTH_W, default 10, meaning log2 of log memory depth in lines; DEPTH = 2^LOG_DEPTH_W.
REQ-002 SHALL have parameter LEN_W, default LOG_DEPTH_W+1, meaning width of line counts, which can hold DEPTH.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have ports resv_req_val (in, 1), resv_req_lines (in, LEN_W) and resv_req_rdy (out, 1), meaning the space reservation request for one log entry.
REQ-006 SHALL have ports resv_resp_val (out, 1), resv_resp_ok (out, 1), resv_resp_base_addr (out, LOG_DEPTH_W) and resv_resp_rdy (in, 1), meaning the reservation result.
REQ-007 SHALL have port log_ctrl_datap_incr_wr_addr, input, 1, meaning a one-cycle pulse per log line written.
REQ-008 SHALL have port datap_wr_addr, output, LOG_DEPTH_W, meaning the current log memory write line address.
REQ-009 SHALL have port datap_ctrl_log_has_space, output, 1, meaning the current entry's reservation was granted.
REQ-010 SHALL have ports reclaim_val (in, 1), reclaim_lines (in, LEN_W) and reclaim_rdy (out, 1), meaning lines freed by log truncation.
REQ-011 SHALL have port used_lines, output, LEN_W, meaning the count of lines reserved and not yet reclaimed.
REQ-012 SHALL have port err_sticky, output, 1, meaning a protocol violation has been seen since reset.

Function
REQ-013 SHALL implement FSM states IDLE, CHECK, RESP and WRITING.
REQ-014 SHALL assert resv_req_rdy only in IDLE; on val&rdy, SHALL latch lines into len_reg and go to CHECK.
REQ-015 In CHECK, SHALL compute ok = (len_reg <= DEPTH - used_lines), register it plus base = wr_ptr, and go to RESP; fixed latency is 2 cycles from accept to resv_resp_val.
REQ-016 In RESP, SHALL hold resv_resp_val=1 with stable ok/base until resv_resp_rdy.
REQ-017 On the RESP handshake with ok=1, SHALL add len_reg to used_lines, load remaining = len_reg, set has_space=1, and go to WRITING; if len_reg==0, SHALL go to IDLE instead.
REQ-018 On the RESP handshake with ok=0, SHALL set has_space=0 and go to IDLE; the writer then drains the entry without incr pulses.
REQ-019 datap_ctrl_log_has_space SHALL hold its value from the RESP handshake until the next RESP handshake.
REQ-020 In WRITING, each incr pulse SHALL increment wr_ptr modulo DEPTH (1023 -> 0) and decrement remaining; on the pulse that takes remaining to 0, SHALL go to IDLE on the next cycle.
REQ-021 An incr pulse outside WRITING SHALL be ignored (wr_ptr unchanged) and SHALL set err_sticky.
REQ-022 reclaim_rdy SHALL be constantly 1; on reclaim_val, used_lines SHALL decrease by reclaim_lines in that cycle.
REQ-023 A simultaneous reclaim and grant SHALL yield used_lines = used + len_reg - reclaim_lines in one cycle.
REQ-024 A reclaim exceeding the available used count SHALL saturate used_lines at 0 and set err_sticky.
REQ-025 The CHECK comparison SHALL use the used_lines register value, so a reclaim in the CHECK cycle is not seen until the next request; this is conservative and never over-grants.
REQ-026 The FSM default branch SHALL drive outputs and next state to X.

Reset
REQ-027 On rst, SHALL set state=IDLE, wr_ptr=0, used_lines=0, remaining=0, has_space=0 and err_sticky=0; resv_req_rdy=1 and resv_resp_val=0 in the first cycle after reset.
REQ-028 Reset mid-WRITING SHALL abandon the reservation with no residual used_lines.

Structure
REQ-029 A shared package SHALL hold the state enum typedef and the LOG_DEPTH_W default constant.
REQ-030 SHALL be a single module with no sub-modules; the modulo wr_ptr counter is inline.

Verification
REQ-031 Reset, then req 4 lines -> resp ok=1, base=0, 2 cycles after accept; 4 incr pulses -> datap_wr_addr=4, used=4, state IDLE.
REQ-032 With used=1020, req 8 -> ok=0, has_space=0, used stays 1020; then reclaim 1020 and req 8 -> ok=1.
REQ-033 With wr_ptr=1022, grant 3 and pulse 3 times -> addresses 1023, 0, 1.
REQ-034 Reclaim 5 in the same cycle as a 3-line grant with used=10 -> used=8.
REQ-035 An incr pulse in IDLE -> wr_ptr unchanged, err_sticky=1; reclaim 9 with used=4 -> used=0, err_sticky=1.
REQ-036 Hold resv_resp_rdy=0 for 5 cycles -> resp fields stable; req 0 lines -> ok=1, returns to IDLE with no incr pulses needed.

Source files
------------

// File: rtl/log_space_ctrl_pkg.sv
// Shared types and defaults for the log space reservation controller.
package log_space_ctrl_pkg;

    localparam int LOG_DEPTH_W_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_RESP    = 2'd2,
        ST_WRITING = 2'd3
    } state_t;

endpackage

// File: rtl/log_space_ctrl.sv
// Reserves line space in a circular log memory, walks the write pointer while an entry is
// written, and tracks used lines against truncation reclaims.
//
// Handshakes: a transfer happens on a rising clk edge where both val and rdy are 1.
// The sender holds val and payload until that edge; rdy never depends on val.
module log_space_ctrl
    import log_space_ctrl_pkg::*;
#(
    parameter int LOG_DEPTH_W = LOG_DEPTH_W_DEF,
    parameter int LEN_W       = LOG_DEPTH_W + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   resv_req_val,
    input  logic [LEN_W-1:0]       resv_req_lines,
    output logic                   resv_req_rdy,
    output logic                   resv_resp_val,
    output logic                   resv_resp_ok,
    output logic [LOG_DEPTH_W-1:0] resv_resp_base_addr,
    input  logic                   resv_resp_rdy,
    input  logic                   log_ctrl_datap_incr_wr_addr,
    output logic [LOG_DEPTH_W-1:0] datap_wr_addr,
    output logic                   datap_ctrl_log_has_space,
    input  logic                   reclaim_val,
    input  logic [LEN_W-1:0]       reclaim_lines,
    output logic                   reclaim_rdy,
    output logic [LEN_W-1:0]       used_lines,
    output logic                   err_sticky,
    output state_t                 dbg_state
);

    localparam int DEPTH = 1 << LOG_DEPTH_W;
    localparam logic [LEN_W:0] DEPTH_X = (LEN_W + 1)'(DEPTH);

    state_t                 state_q, state_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LOG_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]       used_q, used_d;
    logic [LEN_W-1:0]       remaining_q, remaining_d;
    logic                   has_space_q, has_space_d;
    logic                   err_q, err_d;
    logic                   req_rdy_q, req_rdy_d;
    logic                   resp_val_q, resp_val_d;
    logic                   resp_ok_q, resp_ok_d;
    logic [LOG_DEPTH_W-1:0] resp_base_q, resp_base_d;

    logic [LEN_W-1:0]       grant_lines;
    logic [LEN_W:0]         used_sum;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        remaining_d = remaining_q;
        has_space_d = has_space_q;
        resp_ok_d   = resp_ok_q;
        resp_base_d = resp_base_q;
        err_d       = err_q;
        grant_lines = '0;
        used_sum    = '0;
        used_d      = used_q;

        case (state_q)
            ST_IDLE: begin
                if (req_rdy_q && resv_req_val) begin
                    len_d   = resv_req_lines;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Registered used count only: a reclaim landing this cycle is seen next time.
                resp_ok_d   = ({1'b0, len_q} <= (DEPTH_X - {1'b0, used_q}));
                resp_base_d = wr_ptr_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (resv_resp_rdy) begin
                    has_space_d = resp_ok_q;
                    if (resp_ok_q) begin
                        grant_lines = len_q;
                        remaining_d = len_q;
                        state_d     = (len_q == '0) ? ST_IDLE : ST_WRITING;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WRITING: begin
                if (log_ctrl_datap_incr_wr_addr) begin
                    wr_ptr_d    = wr_ptr_q + LOG_DEPTH_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d     = state_t'('x);
                len_d       = 'x;
                wr_ptr_d    = 'x;
                remaining_d = 'x;
                has_space_d = 'x;
                resp_ok_d   = 'x;
                resp_base_d = 'x;
            end
        endcase

        if (log_ctrl_datap_incr_wr_addr && (state_q != ST_WRITING)) begin
            err_d = 1'b1;
        end

        // Grant and reclaim combine in one cycle; an over-reclaim clamps at zero.
        used_sum = {1'b0, used_q} + {1'b0, grant_lines};
        if (reclaim_val) begin
            if ({1'b0, reclaim_lines} > used_sum) begin
                used_d = '0;
                err_d  = 1'b1;
            end else begin
                used_d = LEN_W'(used_sum - {1'b0, reclaim_lines});
            end
        end else begin
            used_d = LEN_W'(used_sum);
        end

        req_rdy_d  = (state_d == ST_IDLE);
        resp_val_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            used_q      <= '0;
            remaining_q <= '0;
            has_space_q <= 1'b0;
            err_q       <= 1'b0;
            req_rdy_q   <= 1'b1;
            resp_val_q  <= 1'b0;
            resp_ok_q   <= 1'b0;
            resp_base_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            used_q      <= used_d;
            remaining_q <= remaining_d;
            has_space_q <= has_space_d;
            err_q       <= err_d;
            req_rdy_q   <= req_rdy_d;
            resp_val_q  <= resp_val_d;
            resp_ok_q   <= resp_ok_d;
            resp_base_q <= resp_base_d;
        end
    end

    assign resv_req_rdy             = req_rdy_q;
    assign resv_resp_val            = resp_val_q;
    assign resv_resp_ok             = resp_ok_q;
    assign resv_resp_base_addr      = resp_base_q;
    assign datap_wr_addr            = wr_ptr_q;
    assign datap_ctrl_log_has_space = has_space_q;
    assign reclaim_rdy              = 1'b1;
    assign used_lines               = used_q;
    assign err_sticky               = err_q;
    assign dbg_state                = state_q;

endmodule

// File: tb/tb_log_space_ctrl.sv
// Directed bench for log_space_ctrl: a transaction-level model checked every cycle,
// plus literal expectations for the main reservation, wrap and reclaim scenarios.
module tb_log_space_ctrl;
    import log_space_ctrl_pkg::*;

    localparam int LOG_DEPTH_W = 10;
    localparam int LEN_W       = 11;
    localparam int DEPTH       = 1024;

    logic                   clk;
    logic                   rst;
    logic                   resv_req_val;
    logic [LEN_W-1:0]       resv_req_lines;
    logic                   resv_req_rdy;
    logic                   resv_resp_val;
    logic                   resv_resp_ok;
    logic [LOG_DEPTH_W-1:0] resv_resp_base_addr;
    logic                   resv_resp_rdy;
    logic                   incr;
    logic [LOG_DEPTH_W-1:0] datap_wr_addr;
    logic                   has_space;
    logic                   reclaim_val;
    logic [LEN_W-1:0]       reclaim_lines;
    logic                   reclaim_rdy;
    logic [LEN_W-1:0]       used_lines;
    logic                   err_sticky;
    state_t                 dbg_state;

    int vectors = 0;
    int miscompares = 0;

    log_space_ctrl #(.LOG_DEPTH_W(LOG_DEPTH_W), .LEN_W(LEN_W)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .resv_req_val                (resv_req_val),
        .resv_req_lines              (resv_req_lines),
        .resv_req_rdy                (resv_req_rdy),
        .resv_resp_val               (resv_resp_val),
        .resv_resp_ok                (resv_resp_ok),
        .resv_resp_base_addr         (resv_resp_base_addr),
        .resv_resp_rdy               (resv_resp_rdy),
        .log_ctrl_datap_incr_wr_addr (incr),
        .datap_wr_addr               (datap_wr_addr),
        .datap_ctrl_log_has_space    (has_space),
        .reclaim_val                 (reclaim_val),
        .reclaim_lines               (reclaim_lines),
        .reclaim_rdy                 (reclaim_rdy),
        .used_lines                  (used_lines),
        .err_sticky                  (err_sticky),
        .dbg_state                   (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks transactions in terms of lines, not controller states.
    bit m_live = 0;
    bit m_rdy, m_rv, m_ok, m_has, m_err;
    int m_used, m_ptr, m_left, m_len, m_base, m_resp_in;

    always @(posedge clk) begin : model
        int  total;
        bit  writing;
        if (rst) begin
            m_live = 1; m_rdy = 1; m_rv = 0; m_ok = 0; m_has = 0; m_err = 0;
            m_used = 0; m_ptr = 0; m_left = 0; m_len = 0; m_base = 0; m_resp_in = 0;
        end else if (m_live) begin
            total   = m_used;
            writing = (m_left > 0);
            if (m_rdy && resv_req_val) begin
                m_rdy = 0; m_len = int'(resv_req_lines); m_resp_in = 1;
            end else if (m_resp_in == 1) begin
                m_resp_in = 0; m_ok = (m_len <= DEPTH - m_used); m_base = m_ptr; m_rv = 1;
            end else if (m_rv && resv_resp_rdy) begin
                m_rv = 0; m_has = m_ok;
                if (m_ok) total += m_len;
                if (m_ok && m_len > 0) m_left = m_len;
                else m_rdy = 1;
            end else if (writing && incr) begin
                m_ptr = (m_ptr + 1) % DEPTH;
                m_left--;
                if (m_left == 0) m_rdy = 1;
            end
            if (incr && !writing) m_err = 1;
            if (reclaim_val) begin
                if (int'(reclaim_lines) > total) begin
                    total = 0; m_err = 1;
                end else begin
                    total -= int'(reclaim_lines);
                end
            end
            m_used = total;
        end
    end

    // Scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (m_live && !rst) begin
            check("req_rdy", resv_req_rdy, m_rdy);
            check("resp_val", resv_resp_val, m_rv);
            if (m_rv) begin
                check("resp_ok", resv_resp_ok, m_ok);
                check("resp_base", resv_resp_base_addr, m_base);
            end
            check("wr_addr", datap_wr_addr, m_ptr);
            check("has_space", has_space, m_has);
            check("used_lines", used_lines, m_used);
            check("err_sticky", err_sticky, m_err);
            check("reclaim_rdy", reclaim_rdy, 1);
        end
    end

    // Driver tasks
    task automatic do_reset();
        rst = 1; resv_req_val = 0; resv_req_lines = '0; resv_resp_rdy = 0;
        incr = 0; reclaim_val = 0; reclaim_lines = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic do_req(input int lines, input int hold, input int rec,
                          output int ok, output int base);
        int c;
        c = 0;
        while (!resv_req_rdy && c < 50) begin
            @(posedge clk); #1; c++;
        end
        check("req_rdy_wait", resv_req_rdy, 1);
        resv_req_val = 1; resv_req_lines = LEN_W'(lines);
        @(posedge clk); #1;
        resv_req_val = 0;
        c = 1;
        while (!resv_resp_val && c < 20) begin
            @(posedge clk); #1; c++;
        end
        check("resp_latency", c, 2);
        ok = int'(resv_resp_ok);
        base = int'(resv_resp_base_addr);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_val", resv_resp_val, 1);
            check("hold_ok", resv_resp_ok, ok);
            check("hold_base", resv_resp_base_addr, base);
        end
        resv_resp_rdy = 1;
        if (rec > 0) begin
            reclaim_val = 1; reclaim_lines = LEN_W'(rec);
        end
        @(posedge clk); #1;
        resv_resp_rdy = 0; reclaim_val = 0;
    endtask

    task automatic do_writes(input int n);
        for (int i = 0; i < n; i++) begin
            incr = 1;
            @(posedge clk); #1;
        end
        incr = 0;
    endtask

    task automatic do_reclaim(input int n);
        reclaim_val = 1; reclaim_lines = LEN_W'(n);
        @(posedge clk); #1;
        reclaim_val = 0;
    endtask

    int ok, base;
    int wrap_exp[3];

    initial begin
        do_reset();
        check("rst_req_rdy", resv_req_rdy, 1);
        check("rst_resp_val", resv_resp_val, 0);
        check("rst_used", used_lines, 0);
        check("rst_addr", datap_wr_addr, 0);
        check("rst_err", err_sticky, 0);

        // Basic 4-line entry
        do_req(4, 0, 0, ok, base);
        check("s1_ok", ok, 1);
        check("s1_base", base, 0);
        do_writes(4);
        check("s1_addr", datap_wr_addr, 4);
        check("s1_used", used_lines, 4);
        check("s1_state", int'(dbg_state), int'(ST_IDLE));

        // Fill to 1020, then a request that does not fit
        do_req(1016, 0, 0, ok, base);
        check("s2_ok", ok, 1);
        do_writes(1016);
        check("s2_used", used_lines, 1020);
        check("s2_addr", datap_wr_addr, 1020);
        do_req(8, 0, 0, ok, base);
        check("full_ok", ok, 0);
        check("full_has_space", has_space, 0);
        check("full_used", used_lines, 1020);
        check("full_rdy", resv_req_rdy, 1);
        do_reclaim(1020);
        check("reclaim_used", used_lines, 0);
        do_req(8, 0, 0, ok, base);
        check("refit_ok", ok, 1);
        check("refit_base", base, 1020);
        check("refit_has_space", has_space, 1);
        do_writes(8);
        check("refit_addr", datap_wr_addr, 4);
        do_reclaim(8);

        // Walk pointer to 1022 then wrap
        do_req(1018, 0, 0, ok, base);
        do_writes(1018);
        check("pre_wrap_addr", datap_wr_addr, 1022);
        do_reclaim(1018);
        do_req(3, 0, 0, ok, base);
        check("wrap_base", base, 1022);
        wrap_exp[0] = 1023; wrap_exp[1] = 0; wrap_exp[2] = 1;
        for (int i = 0; i < 3; i++) begin
            incr = 1;
            @(posedge clk); #1;
            check("wrap_addr", datap_wr_addr, wrap_exp[i]);
        end
        incr = 0;
        check("wrap_used", used_lines, 3);

        // Grant and reclaim in the same cycle
        do_req(7, 0, 0, ok, base);
        do_writes(7);
        check("pre_mix_used", used_lines, 10);
        do_req(3, 0, 5, ok, base);
        check("mix_used", used_lines, 8);
        do_writes(3);
        check("mix_addr", datap_wr_addr, 11);
        check("mix_err", err_sticky, 0);

        // Stray increment while idle
        incr = 1;
        @(posedge clk); #1;
        incr = 0;
        check("stray_addr", datap_wr_addr, 11);
        check("stray_err", err_sticky, 1);

        // Over-reclaim saturates
        do_reset();
        do_req(4, 0, 0, ok, base);
        do_writes(4);
        check("or_pre_err", err_sticky, 0);
        do_reclaim(9);
        check("or_used", used_lines, 0);
        check("or_err", err_sticky, 1);

        // Reset in the middle of writing
        do_reset();
        do_req(5, 0, 0, ok, base);
        do_writes(2);
        check("mid_used", used_lines, 5);
        do_reset();
        check("mid_rst_used", used_lines, 0);
        check("mid_rst_addr", datap_wr_addr, 0);
        check("mid_rst_rdy", resv_req_rdy, 1);

        // Back-pressured response and a zero-line entry
        do_req(0, 5, 0, ok, base);
        check("zero_ok", ok, 1);
        check("zero_base", base, 0);
        check("zero_rdy", resv_req_rdy, 1);
        check("zero_has_space", has_space, 1);
        check("zero_used", used_lines, 0);
        repeat (2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
